mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares one memory port between the core's instruction-fetch port and its data (load/store) port, so a single-ported RAM or external bus can serve the pipelined RV32I core. Data accesses have priority. A starvation counter forces a fetch grant after a bounded number of consecutive data grants. A watchdog aborts transactions that the memory never acknowledges. The block sits between the core and the memory/peripheral interconnect.

Parameters:
FETCH_AFTER, 4, max consecutive data grants while a fetch is pending; the next grant goes to fetch (min 1)
TIMEOUT, 255, cycles without mem_ready before abort; 0 disables the watchdog
CNT_W, 8, width of the timeout counter; must hold TIMEOUT

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
ifetch_req  in  1  fetch request; tie high for the core (fetch always pending)
ifetch_address  in  32  fetch address, held stable until ifetch_ready
ifetch_rdata  out  32  instruction word, valid while ifetch_ready=1
ifetch_ready  out  1  one-cycle completion pulse for fetch
d_address  in  32  data address
d_width  in  2  0=byte, 1=half, 2=word
d_wdata  in  32  store data
d_read  in  1  load request
d_write  in  1  store request
d_rdata  out  32  load data, valid while d_ready=1
d_ready  out  1  one-cycle completion pulse for data
mem_address  out  32  registered address to memory
mem_width  out  2  registered width
mem_wdata  out  32  registered store data
mem_read  out  1  registered read strobe, held until mem_ready
mem_write  out  1  registered write strobe, held until mem_ready
mem_rdata  in  32  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, one cycle
bus_error  out  1  one-cycle pulse on a watchdog abort
grant_owner  out  2  0=none, 1=data, 2=fetch (debug)

Behaviour:
- Reset (async): state IDLE. All outputs 0, including mem_read/mem_write, grant_owner, fetch-starvation counter and timeout counter.
- Reset during a transaction drops the memory strobes immediately. No ready is issued; requesters reissue after reset.
- Requester protocol: the request and its address/data stay stable until the matching ready pulse.
- FSM states: IDLE, DATA, FETCH.
- IDLE, cycle N, grant decision:
  - Data is granted when (d_read|d_write) and (ifetch_req=0 or starve_cnt<FETCH_AFTER); go to DATA.
  - Otherwise fetch is granted when ifetch_req=1; go to FETCH.
  - Otherwise stay in IDLE.
- On grant, the mem_* registers load from the winner at the cycle-N edge. mem_read/mem_write are high from cycle N+1.
- d_read and d_write both high is treated as a write: mem_write=1, mem_read=0.
- Fetch always drives mem_width=2 and mem_wdata=0.
- Starvation counter:
  - +1 on each data grant while ifetch_req=1.
  - Cleared on a fetch grant, or on a data grant with ifetch_req=0.
  - Saturates at FETCH_AFTER.
- DATA/FETCH, cycle M with mem_ready=1:
  - The owner's ready=1 in cycle M (combinational), with rdata=mem_rdata.
  - Strobes clear and state returns to IDLE at the M edge.
  - The non-owner's ready stays 0.
- Minimum latency: request seen at N, mem strobe at N+1, ready at N+1 if memory answers at once. Back-to-back throughput is one access per 2 cycles.
- mem_ready while in IDLE is ignored.
- A requester that withdraws its request mid-transaction does not cancel it: the memory access completes and the ready pulse is still issued.
- Watchdog (TIMEOUT>0):
  - tmo_cnt clears on entering DATA/FETCH and increments each cycle without mem_ready.
  - When tmo_cnt reaches TIMEOUT-1 with no mem_ready, the next cycle drives owner ready=1, rdata=0, bus_error=1 and clears the strobes, then returns to IDLE.
  - If mem_ready coincides with the timeout cycle, normal completion wins and bus_error stays 0.
- grant_owner reflects the state: IDLE=0, DATA=1, FETCH=2.

Test Plan:
- Fetch only: ifetch_req=1, addr 0x100; memory answers 1 cycle after strobe with 0x00000013 -> mem_read at N+1, ifetch_ready with rdata 0x13 at N+2, state IDLE at N+3.
- Data priority: d_read @0x2000, width 2, and ifetch_req together in IDLE -> DATA granted first, mem_address=0x2000; fetch granted on the next IDLE.
- Starvation, FETCH_AFTER=4: continuous d_read plus ifetch_req -> grant order D,D,D,D,F,D,D,D,D,F.
- Store: d_write, d_width=0, addr 0x3001, wdata 0xA5 -> mem_write=1, mem_width=0, mem_wdata=0xA5 held until mem_ready; d_ready one pulse; read and write both high -> mem_read=0.
- Timeout, TIMEOUT=8, memory silent -> after 8 waiting cycles: d_ready=1, d_rdata=0, bus_error=1 for one cycle; mem_read=0 next. mem_ready arriving on that same cycle -> no bus_error, real rdata.
- Async reset asserted mid-FETCH -> mem_read and grant_owner go to 0 without a clock edge; no ready pulse; after release the fetch is regranted cleanly.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: one memory port shared by instruction fetch and data access.
// Data wins ties, a starvation counter bounds fetch delay, a watchdog ends hung accesses.
module mem_bus_arbiter #(
    parameter int FETCH_AFTER = 4,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifetch_req,
    input  logic [31:0] ifetch_address,
    output logic [31:0] ifetch_rdata,
    output logic        ifetch_ready,
    input  logic [31:0] d_address,
    input  logic [1:0]  d_width,
    input  logic [31:0] d_wdata,
    input  logic        d_read,
    input  logic        d_write,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic [31:0] mem_address,
    output logic [1:0]  mem_width,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_error,
    output logic [1:0]  grant_owner
);

    localparam int SW = $clog2(FETCH_AFTER + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t state, next_state;

    logic [SW-1:0]    starve_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             d_req;
    logic             grant_data;
    logic             grant_fetch;
    logic             busy;
    logic             expired;
    logic             done;
    logic [31:0]      rdata_mux;

    assign d_req       = d_read | d_write;
    assign grant_data  = d_req && (!ifetch_req || starve_cnt < SW'(FETCH_AFTER));
    assign grant_fetch = ifetch_req && !grant_data;
    assign busy        = (state != IDLE);
    assign expired     = (TIMEOUT > 0) && (tmo_cnt == CNT_W'(TIMEOUT));
    assign done        = busy && (mem_ready || expired);

    // A watchdog abort returns zero data; a real completion always wins.
    assign rdata_mux    = mem_ready ? mem_rdata : 32'd0;
    assign d_ready      = (state == DATA) && done;
    assign ifetch_ready = (state == FETCH) && done;
    assign d_rdata      = d_ready ? rdata_mux : 32'd0;
    assign ifetch_rdata = ifetch_ready ? rdata_mux : 32'd0;
    assign bus_error    = busy && expired && !mem_ready;
    assign grant_owner  = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (grant_data) begin
                    next_state = DATA;
                end else if (grant_fetch) begin
                    next_state = FETCH;
                end
            end
            DATA, FETCH: begin
                if (done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_address <= '0;
            mem_width   <= '0;
            mem_wdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            starve_cnt  <= '0;
            tmo_cnt     <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
            if (grant_data) begin
                mem_address <= d_address;
                mem_width   <= d_width;
                mem_wdata   <= d_wdata;
                mem_read    <= d_read & ~d_write;
                mem_write   <= d_write;
                // Only data wins taken over a waiting fetch count as starvation.
                if (!ifetch_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != SW'(FETCH_AFTER)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (grant_fetch) begin
                mem_address <= ifetch_address;
                mem_width   <= 2'd2;
                mem_wdata   <= '0;
                mem_read    <= 1'b1;
                mem_write   <= 1'b0;
                starve_cnt  <= '0;
            end
        end else if (done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, corner-case sequences and a randomized
// run against a transaction-level reference model of the arbiter.
module tb_mem_bus_arbiter;

    localparam int FA = 4;
    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifetch_req;
    logic [31:0] ifetch_address;
    logic [31:0] ifetch_rdata;
    logic        ifetch_ready;
    logic [31:0] d_address;
    logic [1:0]  d_width;
    logic [31:0] d_wdata;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [31:0] mem_address;
    logic [1:0]  mem_width;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_error;
    logic [1:0]  grant_owner;

    always #5 clock = ~clock;

    mem_bus_arbiter #(
        .FETCH_AFTER(FA),
        .TIMEOUT(TO),
        .CNT_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ifetch_req(ifetch_req),
        .ifetch_address(ifetch_address),
        .ifetch_rdata(ifetch_rdata),
        .ifetch_ready(ifetch_ready),
        .d_address(d_address),
        .d_width(d_width),
        .d_wdata(d_wdata),
        .d_read(d_read),
        .d_write(d_write),
        .d_rdata(d_rdata),
        .d_ready(d_ready),
        .mem_address(mem_address),
        .mem_width(mem_width),
        .mem_wdata(mem_wdata),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .bus_error(bus_error),
        .grant_owner(grant_owner)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ifetch_req     = 1'b0;
        ifetch_address = '0;
        d_address      = '0;
        d_width        = '0;
        d_wdata        = '0;
        d_read         = 1'b0;
        d_write        = 1'b0;
        mem_rdata      = '0;
        mem_ready      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic        fr;
        logic        dr;
        logic        dw;
        logic [31:0] fa;
        logic [31:0] da;
        logic [31:0] dd;
        logic [1:0]  dwid;
        logic [1:0]  own;
        logic        rd;
        logic        wr;
        logic [1:0]  wid;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdat;
        logic [1:0]  nxt;
    } vec_t;

    vec_t vt[6];

    // reference model state
    int          m_owner;
    int          m_elapsed;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic [1:0]  m_wid;
    logic        m_rd;
    logic        m_wr;
    bit          hist[$];

    // Trailing data grants that were taken while a fetch was waiting.
    function automatic int starve();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (!hist[i] || n >= FA) break;
            n++;
        end
        return n;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit: got timeout want finish");
        $fatal(1);
    end

    initial begin : main
        logic [1:0]  got[10];
        logic [1:0]  exp_order[10];
        int          n;
        bit          f_on, d_on, d_rd, d_wr, silent, busy, done;
        bit          exp_dr, exp_fr;
        logic [31:0] f_addr, d_addr_r, d_wd_r, exp_rd;
        logic [1:0]  d_wid_r;
        int          kind;

        // reset state, with noisy inputs held during reset
        reset = 1'b1;
        idle_inputs();
        d_read    = 1'b1;
        ifetch_req = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_owner", grant_owner, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_width", mem_width, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_f_ready", ifetch_ready, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_f_rdata", ifetch_rdata, 0);
        chk("rst_bus_error", bus_error, 0);

        // grant-decision vectors
        vt[0] = '{1, 0, 0, 32'h100, 0, 0, 0, 2, 1, 0, 2, 32'h100, 0, 32'h13, 2};
        vt[1] = '{1, 1, 0, 32'h104, 32'h2000, 32'h1234, 2, 1, 1, 0, 2, 32'h2000,
                  32'h1234, 32'h1122_3344, 2};
        vt[2] = '{0, 0, 1, 0, 32'h3001, 32'hA5, 0, 1, 0, 1, 0, 32'h3001, 32'hA5,
                  32'h55, 0};
        vt[3] = '{1, 1, 1, 32'h108, 32'h44, 32'h77, 1, 1, 0, 1, 1, 32'h44, 32'h77,
                  32'h99, 2};
        vt[4] = '{0, 0, 0, 32'h10C, 32'h48, 32'h1, 2, 0, 0, 0, 0, 0, 0, 32'h5, 0};
        vt[5] = '{0, 1, 0, 0, 32'h5002, 32'h0, 1, 1, 1, 0, 1, 32'h5002, 0,
                  32'hBEEF, 0};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            ifetch_req     = vt[i].fr;
            ifetch_address = vt[i].fa;
            d_read         = vt[i].dr;
            d_write        = vt[i].dw;
            d_address      = vt[i].da;
            d_width        = vt[i].dwid;
            d_wdata        = vt[i].dd;
            tick();
            chk($sformatf("v%0d_owner", i), grant_owner, vt[i].own);
            chk($sformatf("v%0d_mem_read", i), mem_read, vt[i].rd);
            chk($sformatf("v%0d_mem_write", i), mem_write, vt[i].wr);
            chk($sformatf("v%0d_mem_width", i), mem_width, vt[i].wid);
            chk($sformatf("v%0d_mem_address", i), mem_address, vt[i].addr);
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].wd);
            chk($sformatf("v%0d_no_d_ready", i), d_ready, 0);
            chk($sformatf("v%0d_no_f_ready", i), ifetch_ready, 0);
            tick();
            chk($sformatf("v%0d_hold_read", i), mem_read, vt[i].rd);
            chk($sformatf("v%0d_hold_write", i), mem_write, vt[i].wr);
            mem_ready = 1'b1;
            mem_rdata = vt[i].rdat;
            #1;
            chk($sformatf("v%0d_d_ready", i), d_ready, vt[i].own == 1);
            chk($sformatf("v%0d_f_ready", i), ifetch_ready, vt[i].own == 2);
            if (vt[i].own == 1) chk($sformatf("v%0d_d_rdata", i), d_rdata, vt[i].rdat);
            if (vt[i].own == 2) chk($sformatf("v%0d_f_rdata", i), ifetch_rdata, vt[i].rdat);
            chk($sformatf("v%0d_no_bus_error", i), bus_error, 0);
            tick();
            mem_ready = 1'b0;
            d_read    = 1'b0;
            d_write   = 1'b0;
            #1;
            chk($sformatf("v%0d_back_idle", i), grant_owner, 0);
            chk($sformatf("v%0d_strobe_clear", i), mem_read | mem_write, 0);
            tick();
            chk($sformatf("v%0d_next_owner", i), grant_owner, vt[i].nxt);
        end

        // starvation: continuous data reads with a fetch always pending
        do_reset();
        ifetch_req     = 1'b1;
        ifetch_address = 32'h100;
        d_read         = 1'b1;
        d_address      = 32'h2000;
        d_width        = 2'd2;
        exp_order      = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            tick();
            mem_ready = mem_read | mem_write;
            mem_rdata = $urandom;
            #1;
            if (grant_owner != 0) begin
                got[n] = grant_owner;
                n++;
            end
        end
        chk("starve_grant_count", n, 10);
        for (int i = 0; i < n; i++) chk($sformatf("starve_order_%0d", i), got[i], exp_order[i]);

        // watchdog: silent memory
        do_reset();
        d_read    = 1'b1;
        d_address = 32'h2004;
        d_width   = 2'd2;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        for (int k = 0; k < TO; k++) begin
            chk($sformatf("tmo_wait%0d_read", k), mem_read, 1);
            chk($sformatf("tmo_wait%0d_d_ready", k), d_ready, 0);
            chk($sformatf("tmo_wait%0d_bus_error", k), bus_error, 0);
            tick();
        end
        chk("tmo_d_ready", d_ready, 1);
        chk("tmo_d_rdata", d_rdata, 0);
        chk("tmo_bus_error", bus_error, 1);
        chk("tmo_f_ready", ifetch_ready, 0);
        d_read = 1'b0;
        tick();
        chk("tmo_read_clear", mem_read, 0);
        chk("tmo_err_pulse", bus_error, 0);
        chk("tmo_ready_pulse", d_ready, 0);

        // watchdog: memory answers on the timeout cycle itself
        do_reset();
        d_read    = 1'b1;
        d_address = 32'h2008;
        d_width   = 2'd2;
        tick();
        repeat (TO) tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("tmo_race_d_ready", d_ready, 1);
        chk("tmo_race_d_rdata", d_rdata, 32'hCAFE_F00D);
        chk("tmo_race_bus_error", bus_error, 0);
        tick();
        mem_ready = 1'b0;
        d_read    = 1'b0;

        // async reset mid-fetch
        do_reset();
        ifetch_req     = 1'b1;
        ifetch_address = 32'h400;
        tick();
        chk("arst_pre_owner", grant_owner, 2);
        chk("arst_pre_read", mem_read, 1);
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h13;
        #1;
        chk("arst_owner", grant_owner, 0);
        chk("arst_read", mem_read, 0);
        chk("arst_no_ready", ifetch_ready, 0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        tick();
        chk("arst_regrant_owner", grant_owner, 2);
        chk("arst_regrant_read", mem_read, 1);
        chk("arst_regrant_addr", mem_address, 32'h400);
        mem_ready = 1'b1;
        #1;
        chk("arst_regrant_ready", ifetch_ready, 1);
        chk("arst_regrant_rdata", ifetch_rdata, 32'h13);
        tick();
        ifetch_req = 1'b0;
        mem_ready  = 1'b0;

        // randomized traffic against the reference model
        do_reset();
        m_owner   = 0;
        m_elapsed = 0;
        m_addr    = '0;
        m_wd      = '0;
        m_wid     = '0;
        m_rd      = 1'b0;
        m_wr      = 1'b0;
        hist.delete();
        f_on = 0;
        d_on = 0;
        d_rd = 0;
        d_wr = 0;
        f_addr = '0;
        d_addr_r = '0;
        d_wd_r = '0;
        d_wid_r = '0;
        for (int c = 0; c < 800; c++) begin
            silent = (c >= 450);
            if (!f_on && $urandom_range(0, 2) == 0) begin
                f_on   = 1;
                f_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_on && $urandom_range(0, 2) == 0) begin
                d_on     = 1;
                kind     = $urandom_range(0, 2);
                d_rd     = (kind != 1);
                d_wr     = (kind != 0);
                d_addr_r = $urandom;
                d_wd_r   = $urandom;
                d_wid_r  = 2'($urandom_range(0, 2));
            end
            ifetch_req     = f_on;
            ifetch_address = f_addr;
            d_read         = d_on & d_rd;
            d_write        = d_on & d_wr;
            d_address      = d_addr_r;
            d_width        = d_wid_r;
            d_wdata        = d_wd_r;
            if (m_owner != 0)
                mem_ready = silent ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            else
                mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            #1;
            busy   = (m_owner != 0);
            done   = busy && (mem_ready || m_elapsed > TO);
            exp_dr = (m_owner == 1) && done;
            exp_fr = (m_owner == 2) && done;
            exp_rd = mem_ready ? mem_rdata : 32'd0;
            chk("rnd_owner", grant_owner, m_owner[1:0]);
            chk("rnd_mem_read", mem_read, m_rd);
            chk("rnd_mem_write", mem_write, m_wr);
            chk("rnd_mem_address", mem_address, m_addr);
            chk("rnd_mem_width", mem_width, m_wid);
            chk("rnd_mem_wdata", mem_wdata, m_wd);
            chk("rnd_d_ready", d_ready, exp_dr);
            chk("rnd_f_ready", ifetch_ready, exp_fr);
            chk("rnd_bus_error", bus_error, done && !mem_ready);
            if (exp_dr) chk("rnd_d_rdata", d_rdata, exp_rd);
            if (exp_fr) chk("rnd_f_rdata", ifetch_rdata, exp_rd);
            if (exp_dr) d_on = 0;
            if (exp_fr) f_on = 0;
            // model step for the coming edge
            if (busy) begin
                if (done) begin
                    m_owner = 0;
                    m_rd    = 0;
                    m_wr    = 0;
                end else begin
                    m_elapsed++;
                end
            end else if ((d_read || d_write) && (!ifetch_req || starve() < FA)) begin
                m_owner   = 1;
                m_elapsed = 1;
                m_addr    = d_address;
                m_wid     = d_width;
                m_wd      = d_wdata;
                m_wr      = d_write;
                m_rd      = d_read && !d_write;
                hist.push_back(ifetch_req);
            end else if (ifetch_req) begin
                m_owner   = 2;
                m_elapsed = 1;
                m_addr    = ifetch_address;
                m_wid     = 2'd2;
                m_wd      = '0;
                m_rd      = 1;
                m_wr      = 0;
                hist.push_back(1'b0);
            end
            if (hist.size() > 16) void'(hist.pop_front());
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
